mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-memory interface. Takes one load/store request at a time from the
//  datapath: byte address, size lb/lh/lw/sb/sh/sw, optional sign extension.
//  Drives word-indexed memRead/memWrite/address/write_Data to data memory. Sub-word stores are
//  done as read-modify-write. Sits between the ALU/control stage and the data memory.
// PARAMETERS
//  ADDR_W  6   word-index width; memory depth = 2**ADDR_W words (64)
//  DATA_W  32  word width; fixed at 32, byte lanes derived from it
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset          in   1       synchronous, active-high
//  req_valid      in   1       request present; accepted when req_valid && req_ready
//  req_ready      out  1       high only in IDLE
//  req_write      in   1       1 = store, 0 = load
//  req_size       in   2       00 byte, 01 half, 10 word (11 treated as word)
//  req_signed     in   1       load sign-extends when 1
//  req_addr       in   32      byte address
//  req_wdata      in   32      store data, LSBs used for byte/half
//  resp_done      out  1       one-cycle pulse: request complete
//  resp_rdata     out  32      load result, valid with resp_done and held until the next resp_done
//  resp_err       out  1       misalignment flag, pulses with resp_done (LSU_ALIGN_CHECK_EN only)
//  address        out  32      word index to memory = {zero-ext, addr_q[ADDR_W+1:2]}
//  write_Data     out  32      merged store word
//  memRead        out  1       read strobe; memory read data is combinational
//  memWrite       out  1       write strobe; memory writes at the posedge ending the cycle
//  read_Data      in   32      memory read data
// BEHAVIOUR
//  - Reset values: state=IDLE, req_ready=1, resp_done=0, resp_rdata=0, resp_err=0.
//  - Reset values, continued: memRead=0, memWrite=0, address=0, write_Data=0.
//  - Acceptance: request fields are registered on the accepting edge. The memory strobes are
//    decoded from the state register only, never from req_* inputs.
//  - FSM: IDLE -> RD | WR | DONE(err);  RD -> WR (sub-word store) | DONE;  WR -> DONE;
//    DONE -> IDLE.
//  - Latency from the accept edge to resp_done: lw = 2, sw = 2, sb/sh = 3 cycles.
//    Back-to-back issue rate is 1 request per 3 (word) or 4 (sub-word) cycles.
//  - RD: memRead=1; read_Data is captured at the end of the cycle.
//  - WR: memWrite=1. write_Data = req_wdata for sw, otherwise the captured word with the
//    selected lane(s) replaced.
//  - Byte lanes are big-endian: addr[1:0]=0 maps to bits [31:24], addr[1:0]=3 to bits [7:0].
//    Half-word at addr[1]=0 maps to [31:16]; addr[1]=1 maps to [15:0].
//  - Load extract: the lane is right-justified, then sign-extended if req_signed, else
//    zero-extended. A word load ignores req_signed.
//  - Address bits above ADDR_W+1 are ignored, so the index wraps modulo depth.
//  - Reset sampled mid-operation: the next state is IDLE and no resp_done is issued.
//    A write strobe already high in that cycle is not retracted by this block.
//  - req_valid while busy is ignored; there is no queueing.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined:
//    - A half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> DONE.
//    - No memRead/memWrite is asserted; resp_err=1 with resp_done; resp_rdata is unchanged.
//  LSU_ALIGN_CHECK_EN undefined:
//    - Low address bits are forced aligned (half: addr[0]=0; word: addr[1:0]=0).
//    - resp_err is tied to 0.
// STRUCTURE
//  - Package mips_mem_pkg holds: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the FSM state enum
//    (IDLE, RD, WR, DONE), and the DATA_W constant.
//  - Sub-module mem_lane_align (combinational) does the lane extract with sign/zero extension
//    and the store merge. It is shared by the load path and the RMW path.
// TESTING
//  - Memory preloaded word5=0x00000057, word4=0x0000001A.
//  - lw addr 0x14, unsigned -> lw from word 5 -> rdata 0x00000057, done 2 cycles after accept,
//    one memRead cycle.
//  - sb addr 0x17, wdata 0xFFFFFF80 -> memRead then memWrite.
//    Then word5=0x00000080, and lb signed of 0x17 -> 0xFFFFFF80.
//  - sh addr 0x10, wdata 0x0000BEEF -> word4=0xBEEF001A.
//    Then lh unsigned addr 0x12 -> 0x0000001A.
//  - Addr 0x114, lw (index wraps) -> address=5, rdata 0x00000057.
//    req_valid held high while busy -> no second accept until IDLE.
//  - Reset asserted in the RD cycle of an sb -> no memWrite on later cycles, no resp_done,
//    req_ready=1 the next cycle.
//  - With LSU_ALIGN_CHECK_EN: lw addr 0x15 -> resp_err=1 and resp_done 1 cycle after accept,
//    no strobes.
//    Without it: same access reads word 5.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access unit.
//   DATA_W    : data word width (fixed at 32; byte lanes derive from it)
//   size_e    : request size encodings SZ_BYTE / SZ_HALF / SZ_WORD
//   state_e   : access FSM states IDLE / RD / WR / DONE
//   norm_size : maps the reserved size code 2'b11 onto SZ_WORD
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : size_e'(s);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian byte-lane helper, shared by the load path and the
// read-modify-write store path.
//   word      in  : memory word (fresh read data or the captured RMW word)
//   wdata     in  : store data, LSBs used for byte/half
//   size      in  : access size
//   offset    in  : byte offset within the word (0 selects bits [31:24])
//   sign_ext  in  : sign-extend the extracted lane
//   load_data out : right-justified, sign/zero-extended lane
//   merged    out : word with the selected lane(s) replaced by wdata
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        offset,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]        sh;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] mask;

  always_comb begin
    sh        = '0;
    mask      = '1;
    lane      = '0;
    load_data = word;
    merged    = wdata;
    // Big-endian: lane shift is (3 - offset) bytes, i.e. the inverted offset.
    unique case (size)
      SZ_BYTE: sh = {~offset, 3'b000};
      SZ_HALF: sh = {~offset[1], 4'b0000};
      default: sh = '0;
    endcase
    lane = word >> sh;
    unique case (size)
      SZ_BYTE: begin
        mask      = {{(DATA_W-8){1'b0}}, 8'hFF};
        load_data = {{(DATA_W-8){sign_ext & lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        mask      = {{(DATA_W-16){1'b0}}, 16'hFFFF};
        load_data = {{(DATA_W-16){sign_ext & lane[15]}}, lane[15:0]};
      end
      default: begin
        mask      = '1;
        load_data = word;
      end
    endcase
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores done as
// read-modify-write against a word-indexed memory with combinational read.
// Optional build macro: LSU_ALIGN_CHECK_EN (misaligned half/word accesses are
// rejected with resp_err instead of being forced aligned).
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata : request fields
//   resp_done/resp_rdata/resp_err    : completion pulse, load result, misalign flag
//   address/write_Data/memRead/memWrite/read_Data : memory interface
module mem_access_unit #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_done,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       address,
  output logic [DATA_W-1:0] write_Data,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] read_Data
);

  import mips_mem_pkg::*;

  state_e            state_q, state_d;
  logic              write_q, signed_q;
  size_e             size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, word_q, rdata_q;

  size_e             req_size_n;
  logic              accept;
  logic              misalign;
  logic [ADDR_W+1:0] addr_in;
  logic [DATA_W-1:0] lane_word, load_data, merged;

  // Upper address bits are intentionally discarded: the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_size_n = norm_size(req_size);
  assign accept     = (state_q == IDLE) && req_valid;

  always_comb begin
    misalign = 1'b0;
    addr_in  = req_addr[ADDR_W+1:0];
`ifdef LSU_ALIGN_CHECK_EN
    misalign = ((req_size_n == SZ_HALF) && req_addr[0]) ||
               ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size_n == SZ_HALF) addr_in[0]   = 1'b0;
    if (req_size_n == SZ_WORD) addr_in[1:0] = 2'b00;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign)                               state_d = DONE;
          else if (req_write && req_size_n == SZ_WORD) state_d = WR;
          else                                        state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
  assign resp_err = (state_q == DONE) && err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        size_q   <= req_size_n;
        addr_q   <= addr_in;
        wdata_q  <= req_wdata;
      end
      if (state_q == RD) begin
        word_q <= read_Data;
        if (!write_q) rdata_q <= load_data;
      end
    end
  end

  // Load extraction works on live read data; the RMW merge uses the captured word.
  assign lane_word = (state_q == RD) ? read_Data : word_q;

  mem_lane_align u_align (
    .word      (lane_word),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (signed_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_done  = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign memRead    = (state_q == RD);
  assign memWrite   = (state_q == WR);
  assign address    = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign write_Data = (state_q != WR)      ? '0 :
                      (size_q == SZ_WORD)  ? wdata_q : merged;

endmodule
